// File: rtl/port_capture_if.sv
// rtl/port_capture_if.sv - capture-side and host read-port signal bundle for port_capture
interface port_capture_if #(
    parameter int DW = 15
) ();
    logic          clkEn;
    logic          p0;
    logic          p1;
    logic          p2;
    logic          p3;
    logic [1:0]    portNum;
    logic          serValid;
    logic          done;
    logic          rdReq;
    logic [1:0]    rdPort;
    logic          rdAck;
    logic [DW-1:0] rdData;
    logic [3:0]    rdLen;
    logic [3:0]    frameReady;
    logic [3:0]    overrun;
    logic          lenErr;

    modport master (
        output clkEn, p0, p1, p2, p3, portNum, serValid, done, rdReq, rdPort,
        input  rdAck, rdData, rdLen, frameReady, overrun, lenErr
    );

    modport slave (
        input  clkEn, p0, p1, p2, p3, portNum, serValid, done, rdReq, rdPort,
        output rdAck, rdData, rdLen, frameReady, overrun, lenErr
    );
endinterface

// File: rtl/port_capture.sv
// rtl/port_capture.sv - per-port frame deserializer with host read-back; option macro PORT_CAPTURE_OVERRUN_EN
module port_capture #(
    parameter int DW = 15
) (
    input  logic           clk,
    input  logic           rst,
    port_capture_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CAP, COMMIT} state_t;

    localparam logic [3:0] LEN_MAX = 4'(DW);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] asm_q;
    logic [3:0]    cnt_q;
    logic [1:0]    cap_port;
    logic          len_err;
    logic [DW-1:0] frame_buf [4];
    logic [3:0]    len_q [4];
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic [3:0]    rd_len;
    logic [3:0]    frame_ready;
    logic [3:0]    ready_nxt;
    logic [3:0]    commit_hit;
    logic [3:0]    read_hit;
    logic [3:0]    pv;
    logic          commit;

    assign pv = {bus.p3, bus.p2, bus.p1, bus.p0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.clkEn) begin
            state <= state_nxt;
        end
    end

    // serValid together with done in IDLE yields a one-bit frame committed next cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.done) begin
                    state_nxt = COMMIT;
                end else if (bus.serValid) begin
                    state_nxt = CAP;
                end
            end
            CAP: begin
                if (bus.done) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = bus.clkEn && (state == COMMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q    <= '0;
            cnt_q    <= '0;
            cap_port <= '0;
            len_err  <= 1'b0;
        end else begin
            if (bus.rdReq) begin
                len_err <= 1'b0;
            end
            if (bus.clkEn) begin
                case (state)
                    IDLE: begin
                        if (bus.serValid || bus.done) begin
                            cap_port <= bus.portNum;
                            asm_q    <= {{(DW-1){1'b0}}, bus.serValid & pv[bus.portNum]};
                            cnt_q    <= bus.serValid ? 4'd1 : 4'd0;
                        end
                    end
                    CAP: begin
                        if (bus.serValid) begin
                            if (cnt_q == LEN_MAX) begin
                                len_err <= 1'b1;
                            end else begin
                                asm_q <= {asm_q[DW-2:0], pv[cap_port]};
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                frame_buf[i] <= '0;
                len_q[i]     <= '0;
            end
        end else if (commit) begin
            frame_buf[cap_port] <= asm_q;
            len_q[cap_port]     <= cnt_q;
        end
    end

    // Read port runs every clk; a read in the commit cycle sees the pre-commit contents
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_len  <= '0;
        end else begin
            rd_ack <= bus.rdReq;
            if (bus.rdReq) begin
                rd_data <= frame_buf[bus.rdPort];
                rd_len  <= len_q[bus.rdPort];
            end
        end
    end

    always_comb begin
        commit_hit = 4'b0000;
        read_hit   = 4'b0000;
        if (commit) begin
            commit_hit = 4'b0001 << cap_port;
        end
        if (bus.rdReq) begin
            read_hit = 4'b0001 << bus.rdPort;
        end
        ready_nxt = (frame_ready & ~read_hit) | commit_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ready <= 4'b0000;
        end else begin
            frame_ready <= ready_nxt;
        end
    end

`ifdef PORT_CAPTURE_OVERRUN_EN
    logic [3:0] overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 4'b0000;
        end else begin
            overrun_q <= (overrun_q | (commit_hit & frame_ready)) & ~read_hit;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 4'b0000;
`endif

    assign bus.rdAck      = rd_ack;
    assign bus.rdData     = rd_data;
    assign bus.rdLen      = rd_len;
    assign bus.frameReady = frame_ready;
    assign bus.lenErr     = len_err;
endmodule

// File: doc/port_capture.md
# port_capture

Receive-side collector sitting directly downstream of the serial transmitter datapath. It watches the four demultiplexed port lines `p0`..`p3` and deserializes each transferred frame into a per-port buffer. It flags frame arrival per port and lets a host read back the latest frame and its bit length. It consumes the datapath's port selection and the controller's data-phase and end-of-frame indications.

## Interface
Parameters:
- `DW`, default 15: assembly/buffer width in bits; the maximum frame length, matching the 4-bit data count.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `clkEn` in 1: global clock enable; capture logic advances only when high.
- `p0`,`p1`,`p2`,`p3` in 1: demultiplexer outputs.
- `portNum` in 2: port currently selected by the demultiplexer.
- `serValid` in 1: high while a data bit is on the selected port; one bit per enabled cycle.
- `done` in 1: end-of-frame strobe, one enabled cycle.
- `rdReq` in 1: read request, sampled every `clk` and independent of `clkEn`.
- `rdPort` in 2: port to read.
- `rdAck` out 1: one-cycle read acknowledge.
- `rdData` out DW: frame bits, right-aligned.
- `rdLen` out 4: frame length.
- `frameReady` out 4: sticky per-port "unread frame" flags.
- `overrun` out 4: sticky per-port "unread frame overwritten" flags.
- `lenErr` out 1: sticky; the last frame exceeded DW bits.

## Operation
- Reset state: FSM in IDLE. All buffers, lengths, `rdData`, `rdLen`, `rdAck`, `frameReady`, `overrun` and `lenErr` are 0.
- FSM transitions. All transitions and shifts require `clkEn`=1.
  - IDLE → CAP on `serValid`. The FSM latches `portNum` into `capPort`, clears the assembly register, and shifts in the first bit with length 1.
  - CAP stays in CAP on `serValid`. It shifts left and inserts `p[capPort]` at the LSB (first bit ends up MSB-most), then increments length.
  - CAP → COMMIT on `done`. If `serValid` and `done` are both high in the same cycle, the bit is shifted in first.
  - COMMIT → IDLE after one enabled cycle. In COMMIT the FSM writes the assembly register and length to `buf[capPort]`/`len[capPort]` and sets `frameReady[capPort]`. If that flag was already 1, it also sets `overrun[capPort]`.
- `done` in IDLE with no bits captured commits a zero-length frame to `portNum`, using the same flag rules as a normal commit.
- Length saturation: a bit arriving when the length is already DW is discarded and sets `lenErr`. The commit then carries length DW. `lenErr` clears only on reset or on any read.
- `portNum` changes during CAP are ignored. `capPort` is fixed for the whole frame.
- Read:
  - `rdReq` in cycle N causes `rdAck`=1 in cycle N+1, with `rdData`=`buf[rdPort]` and `rdLen`=`len[rdPort]` registered from cycle N.
  - Cycle N also clears `frameReady[rdPort]` and `overrun[rdPort]`.
  - A read of a port with `frameReady`=0 still acks and returns the stored (stale) contents.
  - `rdData`/`rdLen` hold their value when `rdAck` is 0.
- Commit and read of the same port in the same cycle: the read returns the old contents, `frameReady` ends at 1, and `overrun` ends at 0. Commit and read of different ports proceed independently.
- `rst` mid-frame discards the partial frame and returns to IDLE with all state cleared.

## Timing
- Bit capture: a bit present with `serValid` in enabled cycle N is in the assembly register at N+1.
- Commit: `done` in enabled cycle N puts the FSM in COMMIT at N+1. `frameReady` is visible at N+2 when `clkEn` is continuous.
- Read latency is 1 `clk` cycle regardless of `clkEn`. `rdReq` held high acks every cycle.
- `clkEn` low freezes FSM and capture, but not the read port.
- Minimum frame spacing: `serValid` may rise in the cycle after COMMIT.

## Configuration
- `PORT_CAPTURE_OVERRUN_EN` defined: the overrun detection described above is present.
- `PORT_CAPTURE_OVERRUN_EN` undefined: `overrun` is constant 4'b0000 and commits silently overwrite unread frames. All other behaviour is identical.

## Test plan
- Reset, then drive `portNum`=2 and 5 bits 1,0,1,1,0 on `p2`, then `done` → `frameReady`=4'b0100. Reading port 2 gives `rdAck` one cycle later with `rdData`=15'h0016 and `rdLen`=5, and `frameReady` returns to 0.
- Two unread frames to port 1 (3 bits 111, then 2 bits 01) → `overrun[1]`=1. A read returns `rdData`=1, `rdLen`=2, and clears both flags. Without the macro, `overrun` stays 0.
- 16 bits of all-ones on port 0 → `lenErr`=1, commit length 15, `rdData`=15'h7FFF.
- `done` in IDLE with `portNum`=3 → `frameReady[3]`=1 and a read gives `rdLen`=0. A read of an empty port 0 still acks with the stale data.
- Read of port 1 in the same cycle as a port-1 commit → old data returned, `frameReady[1]`=1, `overrun[1]`=0. A `clkEn` gap mid-frame causes no extra bits. `rst` mid-frame clears everything.
